// File: rtl/riscv_slave_loader.sv
// riscv_slave_loader
//   Feeds the Riscv slave register array. A valid/ready input stream fills
//   entries 0..depth-1 in order; once full, a drain_start pulse reads every
//   entry back in order onto a valid/ready output stream, then re-arms for
//   the next fill.
//
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   s_valid/s_data/s_ready     input word stream
//   drain_start          starts read-back (honoured only when full)
//   m_valid/m_data/m_ready     read-back word stream
//   full                 all depth entries written, awaiting drain
//   done                 one-cycle pulse after the last read-back word is taken
//   fill_count           entries written in the current fill
//   address/w_enable/w_data    slave write/read port
//   r_data               slave read data (one cycle behind address)
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_FILL  | accepting words, writing slave entry wr_ptr
// ST_FULL  | all entries written, input held off, waiting drain_start
// ST_DRAIN | reading entry rd_ptr back, one word per two cycles

module riscv_slave_loader #(
  parameter  int abits       = 4,
  parameter  int depth       = 4,
  parameter  int log2_dbytes = 3,
  localparam int DW          = 8 * (2 ** log2_dbytes),
  localparam int CW          = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          s_valid,
  input  logic [0:DW-1] s_data,
  output logic          s_ready,
  input  logic          drain_start,
  output logic          m_valid,
  output logic [0:DW-1] m_data,
  input  logic          m_ready,
  output logic          full,
  output logic          done,
  output logic [CW-1:0] fill_count,
  output logic [0:abits-1] address,
  output logic          w_enable,
  output logic [0:DW-1] w_data,
  input  logic [0:DW-1] r_data
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  typedef enum logic [1:0] {ST_FILL, ST_FULL, ST_DRAIN} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          primed;
  logic [PW-1:0] addr_ptr;

  assign s_ready  = (state == ST_FILL);
  assign full     = (state == ST_FULL);
  assign w_enable = s_ready & s_valid;
  assign w_data   = s_data;
  // primed means r_data already reflects rd_ptr, i.e. address has been
  // stable for one full cycle.
  assign m_valid  = primed;
  assign m_data   = r_data;

  always_comb begin
    addr_ptr = '0;
    case (state)
      ST_FILL:  addr_ptr = wr_ptr;
      ST_DRAIN: addr_ptr = rd_ptr;
      default:  addr_ptr = '0;
    endcase
  end

  // Pointer zero-extended; numeric LSB lands on address[abits-1].
  assign address = abits'(addr_ptr);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      primed     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_FILL: begin
          if (s_valid) begin
            fill_count <= fill_count + CW'(1);
            if (wr_ptr == LAST) begin
              wr_ptr <= '0;
              state  <= ST_FULL;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        ST_FULL: begin
          if (drain_start) begin
            state  <= ST_DRAIN;
            rd_ptr <= '0;
            primed <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (primed && m_ready) begin
            // Dropping primed forces a fresh read cycle at the new address,
            // which gives the mandated two-cycle word spacing.
            primed <= 1'b0;
            if (rd_ptr == LAST) begin
              done       <= 1'b1;
              state      <= ST_FILL;
              rd_ptr     <= '0;
              wr_ptr     <= '0;
              fill_count <= '0;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end else if (!primed) begin
            primed <= 1'b1;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_slave_loader.sv
module tb_riscv_slave_loader;
  localparam int ABITS = 4;
  localparam int DEPTH = 4;
  localparam int L2B   = 3;
  localparam int DW    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic s_valid = 1'b0;
  logic [0:DW-1] s_data = '0;
  logic s_ready;
  logic drain_start = 1'b0;
  logic m_valid;
  logic [0:DW-1] m_data;
  logic m_ready = 1'b0;
  logic full;
  logic done;
  logic [CW-1:0] fill_count;
  logic [0:ABITS-1] address;
  logic w_enable;
  logic [0:DW-1] w_data;
  logic [0:DW-1] r_data = '0;

  always #5 clk = ~clk;

  riscv_slave_loader #(.abits(ABITS), .depth(DEPTH), .log2_dbytes(L2B)) dut (
    .clk(clk), .nrst(nrst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .drain_start(drain_start),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .full(full), .done(done), .fill_count(fill_count),
    .address(address), .w_enable(w_enable), .w_data(w_data),
    .r_data(r_data)
  );

  // Slave register array: write on the edge, read data one cycle late.
  logic [0:DW-1] mem [0:(2**ABITS)-1];
  initial for (int i = 0; i < 2**ABITS; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (w_enable) mem[address] <= w_data;
    r_data <= mem[address];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s: got no event expected event (t=%0t)", name, $time);
  endtask

  // Reference model: words accepted so far in this fill, and the queue of
  // words expected back from the drain in order.
  typedef enum {M_FILL, M_FULL, M_DRAIN} mode_t;
  mode_t mode = M_FILL;
  int cnt = 0, popped = 0, valid_from = 0, cyc = 0;
  logic [63:0] fill_buf[$];
  logic [63:0] exp_q[$];
  bit exp_done = 0, prev_stall = 0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!nrst) begin
      chk("rst_s_ready", s_ready, 1);
      chk("rst_full", full, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_fill_count", fill_count, 0);
      mode = M_FILL; cnt = 0; popped = 0;
      fill_buf.delete(); exp_q.delete();
      exp_done = 0; prev_stall = 0;
    end else begin
      chk("done", done, exp_done);
      exp_done = 0;
      chk("s_ready", s_ready, mode == M_FILL);
      chk("full", full, mode == M_FULL);
      case (mode)
        M_FILL: begin
          chk("fill_count", fill_count, cnt);
          chk("fill_w_enable", w_enable, s_valid);
          chk("fill_m_valid", m_valid, 0);
          if (s_valid) begin
            chk("fill_address", address, cnt);
            chk("fill_w_data", w_data, s_data);
            fill_buf.push_back(s_data);
            cnt++;
            if (cnt == DEPTH) begin
              mode = M_FULL;
              foreach (fill_buf[i]) exp_q.push_back(fill_buf[i]);
              fill_buf.delete();
            end
          end
        end
        M_FULL: begin
          chk("full_fill_count", fill_count, DEPTH);
          chk("full_w_enable", w_enable, 0);
          chk("full_address", address, 0);
          chk("full_m_valid", m_valid, 0);
          if (drain_start) begin
            mode = M_DRAIN; popped = 0; valid_from = cyc + 2; prev_stall = 0;
          end
        end
        M_DRAIN: begin
          chk("drain_w_enable", w_enable, 0);
          chk("drain_address", address, popped);
          chk("drain_m_valid", m_valid, cyc >= valid_from);
          if (prev_stall) chk("stall_m_data", m_data, prev_data);
          prev_stall = 0;
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
              timeout("scoreboard_empty");
            end else begin
              e = exp_q.pop_front();
              chk("m_data", m_data, e);
            end
            popped++;
            valid_from = cyc + 2;
            if (popped == DEPTH) begin
              mode = M_FILL; cnt = 0; exp_done = 1;
            end
          end else if (m_valid) begin
            prev_stall = 1;
            prev_data = m_data;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic send(input logic [63:0] d);
    bit ok = 0;
    s_valid = 1'b1;
    s_data = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("send");
    @(posedge clk); #1;
  endtask

  task automatic pulse_drain();
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) timeout("done");
    @(posedge clk); #1;
  endtask

  task automatic wait_full();
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (full) begin ok = 1; break; end
    end
    if (!ok) timeout("full");
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input bit noise);
    for (int i = 0; i < DEPTH; i++) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) drain_start = 1'b1;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; drain_start = 1'b0; end
      end
      send({$urandom, $urandom});
    end
    s_valid = 1'b0;
  endtask

  task automatic drain_random();
    bit ok = 0;
    m_ready = 1'b1;
    pulse_drain();
    for (int n = 0; n < 300; n++) begin
      m_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (done) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) timeout("drain_random");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bit ok;
    // Reset with input valid held; first word lands at address 0 on release.
    s_valid = 1'b1;
    s_data = 64'h1111_1111_1111_1111;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    send(64'h1111_1111_1111_1111);
    send(64'h2222_2222_2222_2222);
    send(64'h3333_3333_3333_3333);
    send(64'h4444_4444_4444_4444);
    // Held off while full; this word must go in after the drain.
    s_data = 64'h5555_5555_5555_5555;
    repeat (3) @(posedge clk);
    #1;

    m_ready = 1'b1;
    pulse_drain();
    wait_done();
    s_valid = 1'b0;

    // drain_start during fill is ignored.
    send({$urandom, $urandom});
    s_valid = 1'b0;
    pulse_drain();
    send({$urandom, $urandom});
    send({$urandom, $urandom});
    s_valid = 1'b0;
    wait_full();

    // Stall on the second read-back word for five cycles.
    m_ready = 1'b1;
    pulse_drain();
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("first_word");
    @(posedge clk); #1;
    m_ready = 1'b0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_valid) begin ok = 1; break; end
    end
    if (!ok) timeout("second_word");
    repeat (5) @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done();

    // Randomized fill/drain rounds.
    for (int r = 0; r < 20; r++) begin
      fill_random(1);
      wait_full();
      if ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b1;
        s_data = {$urandom, $urandom};
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 s_valid = 1'b0;
      end
      drain_random();
    end

    // Reset in the middle of a drain after two words.
    fill_random(0);
    wait_full();
    m_ready = 1'b1;
    pulse_drain();
    hs = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      if (hs == 2) break;
    end
    if (hs != 2) timeout("two_words");
    @(posedge clk); #1;
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    fill_random(0);
    wait_full();
    drain_random();

    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
